lsu_ctrl: RTL and testbench

- Multi-cycle load/store sequencer between the RV32I execute stage and a single-port data-memory bus.
- Accepts one LOAD/STORE request at a time and decodes funct3 (LB/LH/LW/LBU/LHU, SB/SH/SW).
- Generates a word-aligned bus transaction with byte enables and lane-replicated write data, then returns load data with sign/zero extension.
- Flags misaligned, illegal, bus-error and timeout conditions.

---
 rtl/lsu_ctrl.sv | 177 +++++++++++++++++
 tb/tb_lsu_ctrl.sv | 297 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/lsu_ctrl.sv
// Load/store sequencer between the RV32I execute stage and a single-port data-memory bus.
// One request in flight: decode, issue a word-aligned bus access, then return extended load data.
module lsu_ctrl #(
    parameter int TIMEOUT_CYCLES = 256
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic        req_is_store,
    input  logic [2:0]  req_funct3,
    input  logic [31:0] req_addr,
    input  logic [31:0] req_wdata,
    output logic        resp_valid,
    output logic [31:0] resp_rdata,
    output logic        resp_err,
    output logic [2:0]  resp_err_code,
    output logic        mem_req,
    output logic        mem_we,
    output logic [31:0] mem_addr,
    output logic [3:0]  mem_be,
    output logic [31:0] mem_wdata,
    input  logic        mem_gnt,
    input  logic        mem_rvalid,
    input  logic [31:0] mem_rdata,
    input  logic        mem_err
);

    localparam logic [1:0] S_IDLE  = 2'd0;
    localparam logic [1:0] S_ISSUE = 2'd1;
    localparam logic [1:0] S_WAIT  = 2'd2;
    localparam logic [1:0] S_RESP  = 2'd3;

    localparam logic [2:0] ERR_OK         = 3'b000;
    localparam logic [2:0] ERR_MISALIGNED = 3'b001;
    localparam logic [2:0] ERR_ILLEGAL    = 3'b010;
    localparam logic [2:0] ERR_BUS        = 3'b011;
    localparam logic [2:0] ERR_TIMEOUT    = 3'b100;

    localparam logic [1:0] SZ_BYTE = 2'b00;
    localparam logic [1:0] SZ_HALF = 2'b01;
    localparam logic [1:0] SZ_WORD = 2'b10;

    // The count can sit one past the limit when a bus event wins the race with the watchdog.
    localparam int              CNT_W     = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES + 1) : 1;
    localparam logic [CNT_W-1:0] CNT_LIMIT = (TIMEOUT_CYCLES > 0) ? CNT_W'(TIMEOUT_CYCLES - 1) : '0;
    localparam logic             WD_ON     = (TIMEOUT_CYCLES > 0);

    logic [1:0]       state;
    logic [CNT_W-1:0] cnt;
    logic [2:0]       op_funct3;
    logic [1:0]       op_lane;

    logic             dec_illegal;
    logic             dec_misaligned;
    logic [3:0]       dec_be;
    logic [31:0]      dec_wdata;
    logic             expired;
    logic [7:0]       byte_lane;
    logic [15:0]      half_lane;
    logic [31:0]      load_data;

    assign req_ready  = (state == S_IDLE);
    assign mem_req    = (state == S_ISSUE);
    assign resp_valid = (state == S_RESP);
    assign resp_err   = (resp_err_code != ERR_OK);
    assign expired    = WD_ON && (cnt >= CNT_LIMIT);

    // NOTE: every signal assigned in always_comb gets a default first, so no path can infer a latch.
    always_comb begin
        dec_be         = 4'b0000;
        dec_wdata      = req_wdata;
        dec_misaligned = 1'b0;
        if (req_is_store)
            dec_illegal = req_funct3[2] || (req_funct3[1:0] == 2'b11);
        else
            dec_illegal = (req_funct3 == 3'b011) || (req_funct3[2:1] == 2'b11);
        case (req_funct3[1:0])
            SZ_BYTE: begin
                dec_be    = 4'b0001 << req_addr[1:0];
                dec_wdata = {4{req_wdata[7:0]}};
            end
            SZ_HALF: begin
                dec_be         = req_addr[1] ? 4'b1100 : 4'b0011;
                dec_wdata      = {2{req_wdata[15:0]}};
                dec_misaligned = req_addr[0];
            end
            SZ_WORD: begin
                dec_be         = 4'b1111;
                dec_misaligned = (req_addr[1:0] != 2'b00);
            end
            default: ;
        endcase
    end

    always_comb begin
        byte_lane = mem_rdata[{op_lane, 3'b000} +: 8];
        half_lane = mem_rdata[{op_lane[1], 4'b0000} +: 16];
        case (op_funct3)
            3'b000:  load_data = {{24{byte_lane[7]}}, byte_lane};
            3'b001:  load_data = {{16{half_lane[15]}}, half_lane};
            3'b100:  load_data = {24'd0, byte_lane};
            3'b101:  load_data = {16'd0, half_lane};
            default: load_data = mem_rdata;
        endcase
    end

    // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge clk) begin
        if (rst) begin
            state         <= S_IDLE;
            cnt           <= '0;
            op_funct3     <= 3'b000;
            op_lane       <= 2'b00;
            mem_we        <= 1'b0;
            mem_addr      <= 32'd0;
            mem_be        <= 4'b0000;
            mem_wdata     <= 32'd0;
            resp_rdata    <= 32'd0;
            resp_err_code <= ERR_OK;
        end else begin
            case (state)
                S_IDLE: begin
                    if (req_valid) begin
                        cnt       <= '0;
                        op_funct3 <= req_funct3;
                        op_lane   <= req_addr[1:0];
                        if (dec_illegal) begin
                            resp_err_code <= ERR_ILLEGAL;
                            state         <= S_RESP;
                        end else if (dec_misaligned) begin
                            resp_err_code <= ERR_MISALIGNED;
                            state         <= S_RESP;
                        end else begin
                            mem_we    <= req_is_store;
                            mem_addr  <= {req_addr[31:2], 2'b00};
                            mem_be    <= dec_be;
                            mem_wdata <= req_is_store ? dec_wdata : 32'd0;
                            state     <= S_ISSUE;
                        end
                    end
                end
                S_ISSUE: begin
                    if (mem_gnt) begin
                        state <= S_WAIT;
                        cnt   <= cnt + 1'b1;
                    end else if (expired) begin
                        resp_err_code <= ERR_TIMEOUT;
                        state         <= S_RESP;
                    end else begin
                        cnt <= cnt + 1'b1;
                    end
                end
                S_WAIT: begin
                    if (mem_rvalid) begin
                        state <= S_RESP;
                        if (mem_err)
                            resp_err_code <= ERR_BUS;
                        else if (!mem_we)
                            resp_rdata <= load_data;
                    end else if (expired) begin
                        resp_err_code <= ERR_TIMEOUT;
                        state         <= S_RESP;
                    end else begin
                        cnt <= cnt + 1'b1;
                    end
                end
                default: begin
                    resp_rdata    <= 32'd0;
                    resp_err_code <= ERR_OK;
                    state         <= S_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_lsu_ctrl.sv
// Directed bench for lsu_ctrl: hand-computed vectors, immediate assertions, watchdog set to 8 cycles.
// Inputs change and outputs are sampled 1 ns after each rising edge.
module tb_lsu_ctrl;

    logic        clk = 1'b0;
    logic        rst;
    logic        req_valid;
    logic        req_ready;
    logic        req_is_store;
    logic [2:0]  req_funct3;
    logic [31:0] req_addr;
    logic [31:0] req_wdata;
    logic        resp_valid;
    logic [31:0] resp_rdata;
    logic        resp_err;
    logic [2:0]  resp_err_code;
    logic        mem_req;
    logic        mem_we;
    logic [31:0] mem_addr;
    logic [3:0]  mem_be;
    logic [31:0] mem_wdata;
    logic        mem_gnt;
    logic        mem_rvalid;
    logic [31:0] mem_rdata;
    logic        mem_err;

    int vectors     = 0;
    int miscompares = 0;

    always #5 clk = ~clk;

    lsu_ctrl #(.TIMEOUT_CYCLES(8)) dut (
        .clk           (clk),
        .rst           (rst),
        .req_valid     (req_valid),
        .req_ready     (req_ready),
        .req_is_store  (req_is_store),
        .req_funct3    (req_funct3),
        .req_addr      (req_addr),
        .req_wdata     (req_wdata),
        .resp_valid    (resp_valid),
        .resp_rdata    (resp_rdata),
        .resp_err      (resp_err),
        .resp_err_code (resp_err_code),
        .mem_req       (mem_req),
        .mem_we        (mem_we),
        .mem_addr      (mem_addr),
        .mem_be        (mem_be),
        .mem_wdata     (mem_wdata),
        .mem_gnt       (mem_gnt),
        .mem_rvalid    (mem_rvalid),
        .mem_rdata     (mem_rdata),
        .mem_err       (mem_err)
    );

    task automatic check(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        vectors++;
        assert (observed === expected)
        else begin
            miscompares++;
            $error("FAIL %s: observed 0x%08h expected 0x%08h", tag, observed, expected);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Present a request for one cycle; returns sampled just after the acceptance edge.
    task automatic request(input logic st, input logic [2:0] f3, input logic [31:0] addr, input logic [31:0] wd);
        req_valid    = 1'b1;
        req_is_store = st;
        req_funct3   = f3;
        req_addr     = addr;
        req_wdata    = wd;
        step();
        req_valid    = 1'b0;
    endtask

    task automatic check_resp(input string tag, input logic [31:0] rdata, input logic [2:0] code);
        check({tag, "_valid"}, resp_valid, 1);
        check({tag, "_rdata"}, resp_rdata, rdata);
        check({tag, "_err"}, resp_err, (code != 3'b000));
        check({tag, "_code"}, resp_err_code, code);
    endtask

    task automatic check_bus(input string tag, input logic we, input logic [31:0] addr,
                             input logic [3:0] be, input logic [31:0] wd);
        check({tag, "_req"}, mem_req, 1);
        check({tag, "_we"}, mem_we, we);
        check({tag, "_addr"}, mem_addr, addr);
        check({tag, "_be"}, mem_be, be);
        check({tag, "_wdata"}, mem_wdata, wd);
    endtask

    initial begin
        rst          = 1'b1;
        req_valid    = 1'b0;
        req_is_store = 1'b0;
        req_funct3   = 3'b000;
        req_addr     = 32'd0;
        req_wdata    = 32'd0;
        mem_gnt      = 1'b0;
        mem_rvalid   = 1'b0;
        mem_rdata    = 32'd0;
        mem_err      = 1'b0;

        // Reset values
        step();
        step();
        check("rst_ready", req_ready, 1);
        check("rst_resp_valid", resp_valid, 0);
        check("rst_resp_err", resp_err, 0);
        check("rst_code", resp_err_code, 0);
        check("rst_rdata", resp_rdata, 0);
        check("rst_mem_req", mem_req, 0);
        check("rst_mem_we", mem_we, 0);
        check("rst_mem_addr", mem_addr, 0);
        check("rst_mem_be", mem_be, 0);
        check("rst_mem_wdata", mem_wdata, 0);
        rst = 1'b0;
        step();

        // LB 0x1003: lane 3 of 0x80FF_1234 is 0x80 -> 0xFFFF_FF80; response in third cycle
        request(1'b0, 3'b000, 32'h0000_1003, 32'h0);
        check("lb_ready", req_ready, 0);
        check_bus("lb_bus", 1'b0, 32'h0000_1000, 4'b1000, 32'h0);
        mem_gnt = 1'b1;
        step();
        mem_gnt = 1'b0;
        check("lb_req_drop", mem_req, 0);
        check("lb_no_early_resp", resp_valid, 0);
        mem_rvalid = 1'b1;
        mem_rdata  = 32'h80FF_1234;
        step();
        mem_rvalid = 1'b0;
        check_resp("lb", 32'hFFFF_FF80, 3'b000);
        step();
        check("lb_resp_pulse", resp_valid, 0);
        check("lb_rdata_clear", resp_rdata, 0);
        check("lb_back_idle", req_ready, 1);

        // SH 0x2002, grant after 4 cycles; a conflicting request is held on the input meanwhile
        request(1'b1, 3'b001, 32'h0000_2002, 32'hDEAD_BEEF);
        req_valid    = 1'b1;
        req_is_store = 1'b0;
        req_funct3   = 3'b010;
        req_addr     = 32'h0000_9990;
        for (int i = 0; i < 5; i++) begin
            check_bus($sformatf("sh_hold%0d", i), 1'b1, 32'h0000_2000, 4'b1100, 32'hBEEF_BEEF);
            if (i == 4)
                mem_gnt = 1'b1;
            step();
        end
        mem_gnt = 1'b0;
        check("sh_req_drop", mem_req, 0);
        mem_rvalid = 1'b1;
        mem_rdata  = 32'h1234_5678;
        req_valid  = 1'b0;
        step();
        mem_rvalid = 1'b0;
        check_resp("sh", 32'h0, 3'b000);
        step();
        check("sh_resp_pulse", resp_valid, 0);

        // LW 0x3001: misaligned, answered the cycle after acceptance with no bus activity
        request(1'b0, 3'b010, 32'h0000_3001, 32'h0);
        check("lw_mis_no_req", mem_req, 0);
        check_resp("lw_mis", 32'h0, 3'b001);
        step();
        check("lw_mis_pulse", resp_valid, 0);
        check("lw_mis_ready", req_ready, 1);

        // Load funct3=011 at a misaligned address: ILLEGAL wins
        request(1'b0, 3'b011, 32'h0000_3001, 32'h0);
        check("ld011_no_req", mem_req, 0);
        check_resp("ld011", 32'h0, 3'b010);
        step();

        // Store funct3=100 is illegal
        request(1'b1, 3'b100, 32'h0000_3000, 32'h0);
        check("st100_no_req", mem_req, 0);
        check_resp("st100", 32'h0, 3'b010);
        step();

        // SB 0x3003: lane 3, byte replicated
        request(1'b1, 3'b000, 32'h0000_3003, 32'h0000_00A5);
        check_bus("sb_bus", 1'b1, 32'h0000_3000, 4'b1000, 32'hA5A5_A5A5);
        mem_gnt = 1'b1;
        step();
        mem_gnt    = 1'b0;
        mem_rvalid = 1'b1;
        step();
        mem_rvalid = 1'b0;
        check_resp("sb", 32'h0, 3'b000);
        step();

        // Watchdog: no grant -> mem_req high for 8 cycles, then TIMEOUT; late rvalid ignored
        request(1'b0, 3'b010, 32'h0000_5000, 32'h0);
        for (int i = 0; i < 8; i++) begin
            check($sformatf("to_req%0d", i), mem_req, 1);
            check($sformatf("to_noresp%0d", i), resp_valid, 0);
            step();
        end
        check("to_req_drop", mem_req, 0);
        check_resp("to", 32'h0, 3'b100);
        mem_rvalid = 1'b1;
        mem_rdata  = 32'h5555_AAAA;
        step();
        check("to_late_rvalid0", resp_valid, 0);
        check("to_ready", req_ready, 1);
        step();
        mem_rvalid = 1'b0;
        check("to_late_rvalid1", resp_valid, 0);

        // LHU 0x4002 with bus error
        request(1'b0, 3'b101, 32'h0000_4002, 32'h0);
        check_bus("lhu_err_bus", 1'b0, 32'h0000_4000, 4'b1100, 32'h0);
        mem_gnt = 1'b1;
        step();
        mem_gnt    = 1'b0;
        mem_rvalid = 1'b1;
        mem_err    = 1'b1;
        mem_rdata  = 32'hFFFF_FFFF;
        step();
        mem_rvalid = 1'b0;
        mem_err    = 1'b0;
        check_resp("lhu_err", 32'h0, 3'b011);
        step();

        // LHU 0x4002 clean; an rvalid in the grant cycle must be ignored
        request(1'b0, 3'b101, 32'h0000_4002, 32'h0);
        mem_gnt    = 1'b1;
        mem_rvalid = 1'b1;
        mem_rdata  = 32'hFFFF_0000;
        step();
        mem_gnt    = 1'b0;
        check("lhu_gnt_rvalid_ignored", resp_valid, 0);
        mem_rdata  = 32'h8001_0000;
        step();
        mem_rvalid = 1'b0;
        check_resp("lhu", 32'h0000_8001, 3'b000);
        step();

        // LH 0x4000: low half 0x8001 sign-extended
        request(1'b0, 3'b001, 32'h0000_4000, 32'h0);
        check_bus("lh_bus", 1'b0, 32'h0000_4000, 4'b0011, 32'h0);
        mem_gnt = 1'b1;
        step();
        mem_gnt    = 1'b0;
        mem_rvalid = 1'b1;
        mem_rdata  = 32'h1234_8001;
        step();
        mem_rvalid = 1'b0;
        check_resp("lh", 32'hFFFF_8001, 3'b000);
        step();

        // Grant and rvalid each coincide with the watchdog limit: bus events win
        request(1'b0, 3'b010, 32'h0000_7000, 32'h0);
        repeat (7) step();
        check("race_still_issue", mem_req, 1);
        mem_gnt = 1'b1;
        step();
        mem_gnt = 1'b0;
        check("race_gnt_wins", resp_valid, 0);
        check("race_in_wait", mem_req, 0);
        mem_rvalid = 1'b1;
        mem_rdata  = 32'hCAFE_F00D;
        step();
        mem_rvalid = 1'b0;
        check_resp("race", 32'hCAFE_F00D, 3'b000);
        step();

        // Reset while in WAIT; stale rvalid afterwards produces nothing
        request(1'b0, 3'b010, 32'h0000_6000, 32'h0);
        mem_gnt = 1'b1;
        step();
        mem_gnt = 1'b0;
        rst     = 1'b1;
        step();
        rst = 1'b0;
        check("rst_wait_ready", req_ready, 1);
        check("rst_wait_mem_req", mem_req, 0);
        check("rst_wait_resp", resp_valid, 0);
        mem_rvalid = 1'b1;
        mem_rdata  = 32'h0BAD_0BAD;
        step();
        mem_rvalid = 1'b0;
        check("rst_stale_resp", resp_valid, 0);
        check("rst_stale_ready", req_ready, 1);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
